// File: rtl/opcode_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the opcode encoder.
// master drives the fields and out_ready, slave is the encoder.
interface opcode_encoder_if #(parameter int ADDR_WIDTH = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            opcode;
  logic [1:0]            encoding;
  logic [1:0]            variant;
  logic [1:0]            operandSize;
  logic [5:0]            register1;
  logic [5:0]            register2;
  logic [5:0]            register3;
  logic [31:0]           immediate;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_word;
  logic                  out_error;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [7:0]            err_count;

  modport master (
    output in_valid, opcode, encoding, variant, operandSize,
           register1, register2, register3, immediate, out_ready,
    input  in_ready, out_valid, out_word, out_error, out_addr, err_count
  );

  modport slave (
    input  in_valid, opcode, encoding, variant, operandSize,
           register1, register2, register3, immediate, out_ready,
    output in_ready, out_valid, out_word, out_error, out_addr, err_count
  );
endinterface

// File: rtl/opcode_encoder.sv
// Packs decoded fields into 32-bit instruction words through a 2-stage valid/ready
// pipeline, flagging unencodable immediates and stamping a wrapping word address.
module opcode_encoder #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  opcode_encoder_if.slave  io_bus
);

  logic [9:0]            w_hdr;
  logic [31:0]           w_word;
  logic                  w_err;
  logic                  w_s2_load;
  logic                  w_s1_adv;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;

  logic                  r_s1_valid;
  logic [31:0]           r_s1_word;
  logic                  r_s1_err;
  logic                  r_s2_valid;
  logic [31:0]           r_s2_word;
  logic                  r_s2_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_err_cnt;

  // Immediate legality: B is unsigned 16-bit, C signed 20-bit, D signed 8-bit.
  always_comb begin
    w_hdr  = {io_bus.variant, io_bus.encoding, io_bus.opcode};
    w_word = '0;
    w_err  = 1'b0;
    case (io_bus.encoding)
      2'd0: w_word = {2'b00, io_bus.operandSize, io_bus.register3,
                      io_bus.register2, io_bus.register1, w_hdr};
      2'd1: begin
        w_err  = |io_bus.immediate[31:16];
        w_word = {io_bus.immediate[15:0], io_bus.register1, w_hdr};
      end
      2'd2: begin
        w_err  = !((&io_bus.immediate[31:19]) || !(|io_bus.immediate[31:19]));
        w_word = {2'b00, io_bus.immediate[19:0], w_hdr};
      end
      default: begin
        w_err  = !((&io_bus.immediate[31:7]) || !(|io_bus.immediate[31:7]));
        w_word = {io_bus.operandSize, io_bus.immediate[7:0],
                  io_bus.register2, io_bus.register1, w_hdr};
      end
    endcase
    if (w_err) w_word = '0;
  end

  assign w_s2_load  = !r_s2_valid || io_bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign w_in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = io_bus.in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && io_bus.out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
      r_s2_err   <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_err_cnt  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_word  <= w_word;
        r_s1_err   <= w_err;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Output register holds its word until the consumer takes it.
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_word <= r_s1_word;
          r_s2_err  <= r_s1_err;
        end
      end

      if (w_out_fire) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (r_s2_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_s2_valid;
  assign io_bus.out_word  = r_s2_word;
  assign io_bus.out_error = r_s2_err;
  assign io_bus.out_addr  = r_addr;
  assign io_bus.err_count = r_err_cnt;

endmodule
